// File: rtl/run_countdown.sv
// -----------------------------------------------------------------------------
// run_countdown
//   HH:MM:SS countdown timer in packed BCD.
//   The preset is mirrored (clamped) while IDLE. A rising edge on go loads the
//   preset and starts counting. A falling edge on go pauses the count. The
//   block alarms when the count reaches zero.
//
// Parameters
//   TICK_DIV  clk cycles per countdown second
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   go       run request level (high = run, low = stop)
//   tmp      preset {hr_10,hr_1,f,min_10,min_1,f,sec_10,sec_1}
//   clr      synchronous clear back to IDLE
//   disp     remaining time, same packing as tmp, separators 4'hf
//   state    IDLE=0, RUN=1, PAUSE=2, DONE=3
//   running  high while state==RUN
//   alarm    high while state==DONE
//   done     one-cycle pulse on entry to DONE
// -----------------------------------------------------------------------------
module run_countdown #(
  parameter int unsigned TICK_DIV = 32'd100000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [31:0] tmp,
  input  logic        clr,
  output logic [31:0] disp,
  output logic [1:0]  state,
  output logic        running,
  output logic        alarm,
  output logic        done
);

  // A divide-by-1 still needs a one-bit prescaler that is always at its max.
  localparam int unsigned   PW      = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [23:0]   cnt_q, cnt_d;      // {hr_10,hr_1,min_10,min_1,sec_10,sec_1}
  logic          go_q;
  logic          running_q, alarm_q, done_q;

  logic          go_rise_s, go_fall_s, tick_s;
  logic [23:0]   preset_s, dec_s;

  // Clamp preset digits into legal BCD ranges (tens of min/sec <= 5).
  function automatic logic [23:0] clamp_preset(input logic [31:0] p);
    logic [3:0] h10, h1, m10, m1, s10, s1;
    h10 = (p[31:28] > 4'd9) ? 4'd9 : p[31:28];
    h1  = (p[27:24] > 4'd9) ? 4'd9 : p[27:24];
    m10 = (p[19:16] > 4'd5) ? 4'd5 : p[19:16];
    m1  = (p[15:12] > 4'd9) ? 4'd9 : p[15:12];
    s10 = (p[7:4]   > 4'd5) ? 4'd5 : p[7:4];
    s1  = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
    return {h10, h1, m10, m1, s10, s1};
  endfunction

  // One-second BCD decrement with borrow ripple; hr_10 never wraps below 0.
  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    logic [23:0] r;
    logic        borrow;
    logic [3:0]  dig;
    logic [3:0]  top;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dig = v[i*4 +: 4];
      if (i == 32'sd5) begin
        top = 4'd0;
      end else if ((i == 32'sd1) || (i == 32'sd3)) begin
        top = 4'd5;
      end else begin
        top = 4'd9;
      end
      if (!borrow) begin
        r[i*4 +: 4] = dig;
      end else if (dig == 4'd0) begin
        r[i*4 +: 4] = top;            // borrow keeps rippling upward
      end else begin
        r[i*4 +: 4] = dig - 4'd1;
        borrow      = 1'b0;
      end
    end
    return r;
  endfunction

  assign go_rise_s = go & ~go_q;
  assign go_fall_s = ~go & go_q;
  assign tick_s    = (pre_q == PRE_MAX);
  assign preset_s  = clamp_preset(tmp);
  assign dec_s     = bcd_dec(cnt_q);

  // Next-state, prescaler and counter logic.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = ST_IDLE;
      pre_d   = '0;
      cnt_d   = preset_s;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = preset_s;
          if (go_rise_s) begin
            state_d = ST_RUN;
            pre_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (cnt_q == 24'h000000) begin
            // A zero load finishes without taking a tick.
            state_d = ST_DONE;
          end else if (tick_s) begin
            pre_d = '0;
            cnt_d = dec_s;
            if (dec_s == 24'h000000) begin
              state_d = ST_DONE;
            end else if (go_fall_s) begin
              state_d = ST_PAUSE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            pre_d = pre_q + {{(PW-1){1'b0}}, 1'b1};
            if (go_fall_s) begin
              state_d = ST_PAUSE;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_PAUSE: begin
          // Prescaler holds so the partial second resumes where it stopped.
          if (go_rise_s) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_DONE: begin
          cnt_d = 24'h000000;
          if (go_fall_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pre_d   = '0;
          cnt_d   = 24'h000000;
        end
      endcase
    end
  end

  // State, counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      cnt_q     <= 24'h000000;
      go_q      <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      go_q      <= go;
      running_q <= (state_d == ST_RUN);
      alarm_q   <= (state_d == ST_DONE);
      done_q    <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  assign disp    = {cnt_q[23:16], 4'hf, cnt_q[15:8], 4'hf, cnt_q[7:0]};
  assign state   = state_q;
  assign running = running_q;
  assign alarm   = alarm_q;
  assign done    = done_q;

endmodule

// File: tb/tb_run_countdown.sv
// -----------------------------------------------------------------------------
// tb_run_countdown
//   Directed bench for run_countdown with TICK_DIV=4. Inputs change just after
//   a falling edge; outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_run_countdown;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic [31:0] tmp;
  logic        clr;
  logic [31:0] disp;
  logic [1:0]  state;
  logic        running;
  logic        alarm;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  run_countdown #(.TICK_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go),
    .tmp     (tmp),
    .clr     (clr),
    .disp    (disp),
    .state   (state),
    .running (running),
    .alarm   (alarm),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    vectors++; if (disp !== 32'h00f00f00) begin miscompares++; $display("FAIL reset_disp: got %h expected %h", disp, 32'h00f00f00); end
    vectors++; if ({state, running, alarm, done} !== 5'b00000) begin miscompares++; $display("FAIL reset_status: got %b expected %b", {state, running, alarm, done}, 5'b00000); end
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(1);
    vectors++; if (disp !== 32'h00f00f03) begin miscompares++; $display("FAIL idle_mirror: got %h expected %h", disp, 32'h00f00f03); end
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL idle_state: got %0d expected 0", state); end
  endtask

  task automatic test_count_down;
    logic [7:0] exp_s;
    go = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_s = (k <= 4) ? 8'h03 : (k <= 8) ? 8'h02 : (k <= 12) ? 8'h01 : 8'h00;
      vectors++; if (disp !== {24'h00f00f, exp_s}) begin miscompares++; $display("FAIL count_disp k=%0d: got %h expected %h", k, disp, {24'h00f00f, exp_s}); end
      vectors++; if (done !== (k == 13)) begin miscompares++; $display("FAIL count_done k=%0d: got %b expected %b", k, done, (k == 13)); end
    end
    vectors++; if ({state, running, alarm} !== {2'd3, 1'b0, 1'b1}) begin miscompares++; $display("FAIL count_alarm: got %b expected %b", {state, running, alarm}, {2'd3, 1'b0, 1'b1}); end
    go = 1'b0;
    @(negedge clk);
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL done_to_idle: got %0d expected 0", state); end
    @(negedge clk);
    vectors++; if (disp !== 32'h00f00f03) begin miscompares++; $display("FAIL done_idle_disp: got %h expected %h", disp, 32'h00f00f03); end
  endtask

  task automatic test_hour_borrow;
    tmp = 32'h01f00f00;
    @(negedge clk);
    vectors++; if (disp !== 32'h01f00f00) begin miscompares++; $display("FAIL hr_mirror: got %h expected %h", disp, 32'h01f00f00); end
    go = 1'b1;
    wait_neg(5);
    vectors++; if (disp !== 32'h00f59f59) begin miscompares++; $display("FAIL hr_borrow: got %h expected %h", disp, 32'h00f59f59); end
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL hr_run_state: got %0d expected 1", state); end
    go = 1'b0;
    @(negedge clk);
    vectors++; if ({state, running} !== {2'd2, 1'b0}) begin miscompares++; $display("FAIL hr_pause: got %b expected %b", {state, running}, {2'd2, 1'b0}); end
    wait_neg(3);
    vectors++; if (disp !== 32'h00f59f59) begin miscompares++; $display("FAIL hr_pause_hold: got %h expected %h", disp, 32'h00f59f59); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL clr_pause_state: got %0d expected 0", state); end
    vectors++; if (disp !== 32'h01f00f00) begin miscompares++; $display("FAIL clr_pause_disp: got %h expected %h", disp, 32'h01f00f00); end
  endtask

  task automatic test_pause_resume;
    tmp = 32'h00f00f10;
    @(negedge clk);
    go = 1'b1;
    wait_neg(5);
    vectors++; if (disp !== 32'h00f00f09) begin miscompares++; $display("FAIL pr_first_tick: got %h expected %h", disp, 32'h00f00f09); end
    go = 1'b0;
    @(negedge clk);
    vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL pr_pause: got %0d expected 2", state); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vectors++; if ({state, disp} !== {2'd2, 32'h00f00f09}) begin miscompares++; $display("FAIL pr_hold k=%0d: got %h expected %h", k, {state, disp}, {2'd2, 32'h00f00f09}); end
    end
    go = 1'b1;
    @(negedge clk);
    vectors++; if ({state, disp} !== {2'd1, 32'h00f00f09}) begin miscompares++; $display("FAIL pr_resume: got %h expected %h", {state, disp}, {2'd1, 32'h00f00f09}); end
    wait_neg(2);
    vectors++; if (disp !== 32'h00f00f09) begin miscompares++; $display("FAIL pr_pre_held: got %h expected %h", disp, 32'h00f00f09); end
    @(negedge clk);
    vectors++; if (disp !== 32'h00f00f08) begin miscompares++; $display("FAIL pr_next_tick: got %h expected %h", disp, 32'h00f00f08); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    vectors++; if ({state, running, disp} !== {2'd0, 1'b0, 32'h00f00f10}) begin miscompares++; $display("FAIL clr_run: got %h expected %h", {state, running, disp}, {2'd0, 1'b0, 32'h00f00f10}); end
    go = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tick_and_fall;
    tmp = 32'h00f00f05;
    @(negedge clk);
    go = 1'b1;
    wait_neg(4);
    go = 1'b0;
    @(negedge clk);
    vectors++; if ({state, disp} !== {2'd2, 32'h00f00f04}) begin miscompares++; $display("FAIL tf_pause: got %h expected %h", {state, disp}, {2'd2, 32'h00f00f04}); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    tmp = 32'h00f00f01;
    @(negedge clk);
    go = 1'b1;
    wait_neg(4);
    go = 1'b0;
    @(negedge clk);
    vectors++; if ({state, done, alarm, disp} !== {2'd3, 1'b1, 1'b1, 32'h00f00f00}) begin miscompares++; $display("FAIL tf_done_wins: got %h expected %h", {state, done, alarm, disp}, {2'd3, 1'b1, 1'b1, 32'h00f00f00}); end
    @(negedge clk);
    vectors++; if ({state, done} !== {2'd3, 1'b0}) begin miscompares++; $display("FAIL tf_done_stay: got %b expected %b", {state, done}, {2'd3, 1'b0}); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    vectors++; if ({state, alarm, disp} !== {2'd0, 1'b0, 32'h00f00f01}) begin miscompares++; $display("FAIL clr_done: got %h expected %h", {state, alarm, disp}, {2'd0, 1'b0, 32'h00f00f01}); end
  endtask

  task automatic test_zero_load;
    tmp = 32'h00f00f00;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    vectors++; if ({state, done, disp} !== {2'd1, 1'b0, 32'h00f00f00}) begin miscompares++; $display("FAIL zero_load: got %h expected %h", {state, done, disp}, {2'd1, 1'b0, 32'h00f00f00}); end
    @(negedge clk);
    vectors++; if ({state, done, disp} !== {2'd3, 1'b1, 32'h00f00f00}) begin miscompares++; $display("FAIL zero_done: got %h expected %h", {state, done, disp}, {2'd3, 1'b1, 32'h00f00f00}); end
    @(negedge clk);
    vectors++; if ({done, alarm, running} !== 3'b010) begin miscompares++; $display("FAIL zero_alarm: got %b expected %b", {done, alarm, running}, 3'b010); end
    go = 1'b0;
    @(negedge clk);
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL zero_idle: got %0d expected 0", state); end
  endtask

  task automatic test_clamp;
    tmp = 32'h9af7ff7c;
    @(negedge clk);
    vectors++; if ({state, disp} !== {2'd0, 32'h99f59f59}) begin miscompares++; $display("FAIL clamp: got %h expected %h", {state, disp}, {2'd0, 32'h99f59f59}); end
    go = 1'b1;
    wait_neg(5);
    vectors++; if (disp !== 32'h99f59f58) begin miscompares++; $display("FAIL clamp_tick: got %h expected %h", disp, 32'h99f59f58); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    go  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    tmp = 32'h00f00f03;
    @(negedge clk);
    go = 1'b1;
    wait_neg(2);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({state, running, disp} !== {2'd0, 1'b0, 32'h00f00f00}) begin miscompares++; $display("FAIL async_reset: got %h expected %h", {state, running, disp}, {2'd0, 1'b0, 32'h00f00f00}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if ({state, disp} !== {2'd1, 32'h00f00f03}) begin miscompares++; $display("FAIL release_start: got %h expected %h", {state, disp}, {2'd1, 32'h00f00f03}); end
    wait_neg(4);
    vectors++; if (disp !== 32'h00f00f02) begin miscompares++; $display("FAIL release_tick: got %h expected %h", disp, 32'h00f00f02); end
    go  = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    go    = 1'b0;
    clr   = 1'b0;
    tmp   = 32'h00f00f03;
    test_reset;
    test_count_down;
    test_hour_borrow;
    test_pause_resume;
    test_tick_and_fall;
    test_zero_load;
    test_clamp;
    test_reset_mid_run;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
